// File: rtl/pb_repeat_debounce.sv
// Push-button conditioner: sync + press/release debounce, one pulse per press plus auto-repeat.
// Latency: press pulse/level after DEBOUNCE_CYCLES+3 edges of stable input; release after the same.
// Backpressure: none; free-running, pulses are single-cycle strobes and cannot be stalled.
//
// Ports:
//   clk          system clock, all logic on rising edge
//   reset        asynchronous, active-high; clears all state
//   button_in    raw asynchronous bouncing button (1 = pressed)
//   button_level debounced button level
//   button_pulse one-cycle strobe per accepted press and per repeat
//   long_press   high while auto-repeat is active
module pb_repeat_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int REPEAT_EN       = 1,
   parameter int CNT_W           = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic button_in,
   output logic button_level,
   output logic button_pulse,
   output logic long_press
);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD         = 3'd2,
      REPEAT       = 3'd3,
      RELEASE_WAIT = 3'd4
   } state_t;

   // Terminal counts; the counter runs 0..N-1 so each wait lasts exactly N edges.
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync_q1;
   logic             sync_q2;
   logic             s;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchroniser; only the second stage feeds decisions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= button_in;
         sync_q2 <= sync_q1;
      end
   end

   assign s = sync_q2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         button_level <= 1'b0;
         button_pulse <= 1'b0;
         long_press   <= 1'b0;
      end else begin
         // Strobe is asserted only by the branches below, for a single cycle.
         button_pulse <= 1'b0;

         case (state)
            IDLE: begin
               if (s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end

            PRESS_WAIT: begin
               if (!s) begin
                  // Bounce before the press was accepted: start over silently.
                  state <= IDLE;
               end else if (cnt == DB_LAST) begin
                  state        <= HELD;
                  cnt          <= '0;
                  button_level <= 1'b1;
                  button_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            HELD: begin
               // A release seen on the terminal cycle wins; no repeat is issued.
               if (!s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end else if ((REPEAT_EN != 0) && (cnt == RD_LAST)) begin
                  state        <= REPEAT;
                  cnt          <= '0;
                  button_pulse <= 1'b1;
                  long_press   <= 1'b1;
               end else if (cnt != RD_LAST) begin
                  // Without auto-repeat the counter parks at the terminal value.
                  cnt <= cnt + CNT_ONE;
               end
            end

            REPEAT: begin
               if (!s) begin
                  state      <= RELEASE_WAIT;
                  cnt        <= '0;
                  long_press <= 1'b0;
               end else if (cnt == RR_LAST) begin
                  cnt          <= '0;
                  button_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            RELEASE_WAIT: begin
               if (s) begin
                  // Release bounce: still pressed, but the repeat delay restarts.
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  state        <= IDLE;
                  cnt          <= '0;
                  button_level <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            default: begin
               state        <= IDLE;
               cnt          <= '0;
               button_level <= 1'b0;
               long_press   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pb_repeat_debounce.sv
module tb_pb_repeat_debounce;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RR = 5;
   localparam int W  = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       button_in;
   logic [1:0] lvl;
   logic [1:0] pls;
   logic [1:0] lng;

   // Instance 0: auto-repeat enabled; instance 1: single pulse per press.
   pb_repeat_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                        .REPEAT_EN(1), .CNT_W(W)) dut0 (
      .clk(clk), .reset(reset), .button_in(button_in),
      .button_level(lvl[0]), .button_pulse(pls[0]), .long_press(lng[0]));

   pb_repeat_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                        .REPEAT_EN(0), .CNT_W(W)) dut1 (
      .clk(clk), .reset(reset), .button_in(button_in),
      .button_level(lvl[1]), .button_pulse(pls[1]), .long_press(lng[1]));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: two-sample input delay, then run-length debounce and an
   // absolute-edge schedule for repeat pulses.
   bit ren [2] = '{1'b1, 1'b0};
   bit h1, h2;
   int m_run  [2];
   bit m_lvl  [2];
   bit m_long [2];
   bit m_pls  [2];
   int m_next [2];
   int ecnt = 0;
   int rel  = 0;
   int pq[$];
   int cnt1 = 0;
   int long_first = -1;

   task automatic model_reset();
      h1 = 1'b0;
      h2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_run[i]  = 0;
         m_lvl[i]  = 1'b0;
         m_long[i] = 1'b0;
         m_pls[i]  = 1'b0;
         m_next[i] = -1;
      end
   endtask

   task automatic model_edge();
      bit sv;
      sv = h2;
      h2 = h1;
      h1 = button_in;
      for (int i = 0; i < 2; i++) begin
         m_pls[i] = 1'b0;
         if (!m_lvl[i]) begin
            if (sv) begin
               m_run[i]++;
               if (m_run[i] == D + 1) begin
                  m_lvl[i]  = 1'b1;
                  m_pls[i]  = 1'b1;
                  m_run[i]  = 0;
                  m_next[i] = ecnt + RD;
               end
            end else begin
               m_run[i] = 0;
            end
         end else begin
            if (!sv) begin
               m_run[i]++;
               m_long[i] = 1'b0;
               m_next[i] = -1;
               if (m_run[i] == D + 1) begin
                  m_lvl[i] = 1'b0;
                  m_run[i] = 0;
               end
            end else if (m_run[i] > 0) begin
               m_run[i]  = 0;
               m_next[i] = ecnt + RD;
            end else if (ren[i] && ecnt == m_next[i]) begin
               m_pls[i]  = 1'b1;
               m_long[i] = 1'b1;
               m_next[i] = ecnt + RR;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ecnt++;
      rel++;
      if (reset) model_reset();
      else model_edge();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("level%0d", i), lvl[i], m_lvl[i]);
         chk($sformatf("pulse%0d", i), pls[i], m_pls[i]);
         chk($sformatf("long%0d", i),  lng[i], m_long[i]);
      end
      if (pls[0] === 1'b1) pq.push_back(rel);
      if (pls[1] === 1'b1) cnt1++;
      if (lng[0] === 1'b1 && long_first < 0) long_first = rel;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         chk("rst_level", lvl[i], 0);
         chk("rst_pulse", pls[i], 0);
         chk("rst_long",  lng[i], 0);
      end
      repeat (n) tick();
      reset = 1'b0;
   endtask

   function automatic int pq_at(input int k);
      return (pq.size() > k) ? pq[k] : -1;
   endfunction

   int exp4 [6] = '{7, 17, 22, 27, 32, 37};

   initial begin
      reset     = 1'b1;
      button_in = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset(3);

      // Idle after reset: nothing happens.
      pq.delete();
      repeat (50) tick();
      chk("idle_npulse", pq.size(), 0);

      // Clean press, held 12 cycles.
      button_in = 1'b1; rel = 0; pq.delete();
      repeat (12) tick();
      button_in = 1'b0;
      repeat (12) tick();
      chk("clean_npulse", pq.size(), 1);
      chk("clean_edge", pq_at(0), 7);

      // Press bounce, then stable.
      pq.delete();
      for (int k = 0; k < 8; k++) begin
         button_in = ~k[1];
         tick();
      end
      chk("bounce_quiet", pq.size(), 0);
      button_in = 1'b1; rel = 0;
      repeat (9) tick();
      button_in = 1'b0;
      repeat (12) tick();
      chk("bounce_npulse", pq.size(), 1);
      chk("bounce_edge", pq_at(0), 7);

      // Long hold with auto-repeat; repeat-disabled instance gives one pulse.
      button_in = 1'b1; rel = 0; pq.delete(); cnt1 = 0; long_first = -1;
      repeat (40) tick();
      button_in = 1'b0;
      repeat (12) tick();
      for (int k = 0; k < 6; k++) chk($sformatf("hold_edge%0d", k), pq_at(k), exp4[k]);
      chk("hold_long_start", long_first, 17);
      chk("norepeat_npulse", cnt1, 1);

      // Release bounce in HELD, coinciding with the repeat terminal count.
      button_in = 1'b1; rel = 0; pq.delete();
      repeat (14) tick();
      button_in = 1'b0;
      repeat (2) tick();
      button_in = 1'b1;
      repeat (20) tick();
      button_in = 1'b0;
      repeat (12) tick();
      chk("relb_press", pq_at(0), 7);
      chk("relb_repeat", pq_at(1), 29);

      // Reset during REPEAT with the button still held.
      button_in = 1'b1; rel = 0;
      repeat (20) tick();
      do_reset(2);
      rel = 0; pq.delete(); cnt1 = 0;
      repeat (10) tick();
      chk("rst_repress", pq_at(0), 7);
      chk("rst_repress1", cnt1, 1);
      button_in = 1'b0;
      repeat (12) tick();

      // Randomised segments with occasional resets and short glitches.
      for (int seg = 0; seg < 300; seg++) begin
         int r;
         int dur;
         r = $urandom_range(0, 9);
         if (r == 0 && ($urandom % 3) == 0) do_reset($urandom_range(1, 3));
         button_in = 1'($urandom_range(0, 1));
         if (r < 3) dur = $urandom_range(1, 3);
         else if (r < 7) dur = $urandom_range(4, 12);
         else dur = $urandom_range(20, 45);
         repeat (dur) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
